demux1to2_stream: RTL and testbench

DEMUX1TO2_STREAM -- requirements
Module: demux1to2_stream

---
 rtl/demux1to2_stream.sv | 97 +++++++++
 tb/tb_demux1to2_stream.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1to2_stream.sv
// 1-to-2 stream demultiplexer with one registered entry per output channel,
// select-or-round-robin routing, and per-channel delivered-beat counters.
module demux1to2_stream #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i,
    input  logic             i_valid,
    input  logic             s,
    input  logic             alt,
    output logic             i_ready,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic             o0_valid,
    output logic             o1_valid,
    input  logic             o0_ready,
    input  logic             o1_ready,
    output logic [CNTW-1:0]  cnt0,
    output logic [CNTW-1:0]  cnt1
);

    logic [WIDTH-1:0] data_q [2];
    logic [WIDTH-1:0] data_d [2];
    logic [CNTW-1:0]  cnt_q  [2];
    logic [CNTW-1:0]  cnt_d  [2];
    logic [1:0]       valid_q, valid_d;
    logic             rr_q, rr_d;

    logic       dsel;
    logic [1:0] sink_ready;
    logic [1:0] drain;
    logic       accept;

    assign dsel       = alt ? rr_q : s;
    assign sink_ready = {o1_ready, o0_ready};
    assign drain      = valid_q & sink_ready;

    // The selected entry can take a beat if it is empty or emptying this edge.
    assign i_ready = ~valid_q[dsel] | sink_ready[dsel];
    assign accept  = i_valid & i_ready;

    // NOTE: every next-state value is defaulted to its current value first, so
    // no path through this block leaves a variable unassigned and infers a latch.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;

        for (int n = 0; n < 2; n++) begin
            if (drain[n]) begin
                valid_d[n] = 1'b0;
                cnt_d[n]   = cnt_q[n] + 1'b1;
            end
        end

        // A reload on the same edge as a drain wins: the entry stays valid.
        if (accept) begin
            valid_d[dsel] = 1'b1;
            data_d[dsel]  = i;
            if (alt) begin
                rr_d = ~rr_q;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the data entries are reset too because o0/o1 must
    // read zero while in reset, not merely be qualified by their valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rr_q    <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                data_q[n] <= '0;
                cnt_q[n]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rr_q    <= rr_d;
            for (int n = 0; n < 2; n++) begin
                data_q[n] <= data_d[n];
                cnt_q[n]  <= cnt_d[n];
            end
        end
    end

    assign o0       = data_q[0];
    assign o1       = data_q[1];
    assign o0_valid = valid_q[0];
    assign o1_valid = valid_q[1];
    assign cnt0     = cnt_q[0];
    assign cnt1     = cnt_q[1];

endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed self-checking bench for demux1to2_stream: routing, backpressure,
// simultaneous accept/drain, counter wrap and asynchronous reset.
module tb_demux1to2_stream;

    localparam int WIDTH = 8;
    localparam int CNTW  = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] i;
    logic             i_valid;
    logic             s;
    logic             alt;
    logic             i_ready;
    logic [WIDTH-1:0] o0;
    logic [WIDTH-1:0] o1;
    logic             o0_valid;
    logic             o1_valid;
    logic             o0_ready;
    logic             o1_ready;
    logic [CNTW-1:0]  cnt0;
    logic [CNTW-1:0]  cnt1;

    int pass_cnt  = 0;
    int check_cnt = 0;

    demux1to2_stream #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i        (i),
        .i_valid  (i_valid),
        .s        (s),
        .alt      (alt),
        .i_ready  (i_ready),
        .o0       (o0),
        .o1       (o1),
        .o0_valid (o0_valid),
        .o1_valid (o1_valid),
        .o0_ready (o0_ready),
        .o1_ready (o1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        i        = '0;
        i_valid  = 1'b0;
        s        = 1'b0;
        alt      = 1'b0;
        o0_ready = 1'b0;
        o1_ready = 1'b0;

        // Reset state, before any clock edge
        #3;
        check("rst_o0_valid", o0_valid, 0);
        check("rst_o1_valid", o1_valid, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_o0", o0, 0);
        check("rst_o1", o1, 0);
        check("rst_i_ready", i_ready, 1);
        tick();
        rst_n = 1'b1;

        // Single beat to out0
        alt = 1'b0; s = 1'b0; i = 8'hA5; i_valid = 1'b1; o0_ready = 1'b1;
        #1 check("single_i_ready", i_ready, 1);
        tick();
        i_valid = 1'b0;
        check("single_o0", o0, 8'hA5);
        check("single_o0_valid", o0_valid, 1);
        check("single_o1_valid", o1_valid, 0);
        check("single_cnt0_pre", cnt0, 0);
        tick();
        check("single_o0_valid_gone", o0_valid, 0);
        check("single_cnt0", cnt0, 1);

        // Round-robin: 01,02,03,04 back to back, both sinks ready
        alt = 1'b1; o1_ready = 1'b1;
        i = 8'h01; i_valid = 1'b1;
        tick();
        check("rr_o0_first", o0, 8'h01);
        check("rr_o0_valid_first", o0_valid, 1);
        i = 8'h02;
        tick();
        check("rr_o1_first", o1, 8'h02);
        check("rr_o1_valid_first", o1_valid, 1);
        check("rr_o0_drained", o0_valid, 0);
        i = 8'h03;
        tick();
        check("rr_o0_second", o0, 8'h03);
        check("rr_o1_drained", o1_valid, 0);
        i = 8'h04;
        tick();
        check("rr_o1_second", o1, 8'h04);
        check("rr_o0_valid_mid", o0_valid, 0);
        i_valid = 1'b0;
        tick();
        check("rr_o1_valid_end", o1_valid, 0);
        check("rr_cnt0", cnt0, 3);
        check("rr_cnt1", cnt1, 2);

        // Backpressure on out1
        alt = 1'b0; s = 1'b1; o1_ready = 1'b0;
        i = 8'h11; i_valid = 1'b1;
        #1 check("bp_i_ready_first", i_ready, 1);
        tick();
        check("bp_o1_first", o1, 8'h11);
        check("bp_o1_valid_first", o1_valid, 1);
        i = 8'h22;
        #1 check("bp_i_ready_stall", i_ready, 0);
        tick();
        check("bp_o1_held", o1, 8'h11);
        check("bp_i_ready_still_stall", i_ready, 0);
        tick();
        check("bp_o1_held2", o1, 8'h11);
        o1_ready = 1'b1;
        #1 check("bp_i_ready_release", i_ready, 1);
        tick();
        i_valid = 1'b0;
        check("bp_o1_second", o1, 8'h22);
        check("bp_o1_valid_second", o1_valid, 1);
        check("bp_cnt1_mid", cnt1, 3);
        tick();
        check("bp_o1_valid_end", o1_valid, 0);
        check("bp_cnt1", cnt1, 4);

        // Accept on out1 while stalled out0 drains on the same edge
        s = 1'b0; o0_ready = 1'b0; o1_ready = 1'b0;
        i = 8'h44; i_valid = 1'b1;
        tick();
        check("sim_o0_full", o0, 8'h44);
        check("sim_o0_valid_full", o0_valid, 1);
        s = 1'b1; i = 8'h33; o0_ready = 1'b1;
        #1 check("sim_i_ready", i_ready, 1);
        tick();
        i_valid = 1'b0;
        check("sim_o1", o1, 8'h33);
        check("sim_o1_valid", o1_valid, 1);
        check("sim_o0_valid", o0_valid, 0);
        check("sim_cnt0", cnt0, 4);
        check("sim_cnt1_hold", cnt1, 4);
        o1_ready = 1'b1;
        tick();
        check("sim_o1_drained", o1_valid, 0);
        check("sim_cnt1", cnt1, 5);

        // Reset mid-operation with both entries full and rr=1
        o0_ready = 1'b0; o1_ready = 1'b0;
        alt = 1'b1; i = 8'h66; i_valid = 1'b1;
        tick();
        check("mid_o0_loaded", o0, 8'h66);
        alt = 1'b0; s = 1'b1; i = 8'h77;
        tick();
        check("mid_o1_loaded", o1, 8'h77);
        check("mid_both_valid", {o1_valid, o0_valid}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_o0_valid", o0_valid, 0);
        check("mid_rst_o1_valid", o1_valid, 0);
        check("mid_rst_cnt0", cnt0, 0);
        check("mid_rst_cnt1", cnt1, 0);
        check("mid_rst_o0", o0, 0);
        check("mid_rst_o1", o1, 0);
        check("mid_rst_i_ready", i_ready, 1);
        tick();
        check("mid_rst_no_accept", {o1_valid, o0_valid}, 2'b00);
        rst_n = 1'b1;
        alt = 1'b1; i = 8'h88; i_valid = 1'b1; o0_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        check("post_rst_o0", o0, 8'h88);
        check("post_rst_o0_valid", o0_valid, 1);
        check("post_rst_o1_valid", o1_valid, 0);
        tick();
        check("post_rst_cnt0", cnt0, 1);

        // Counter wrap: fresh reset, then 17 beats to out0 with sink ready
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        alt = 1'b0; s = 1'b0; o0_ready = 1'b1; i_valid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            i = WIDTH'(8'hC0 + k);
            tick();
            check($sformatf("wrap_o0_%0d", k), o0, 32'(8'hC0 + k));
            check($sformatf("wrap_cnt0_%0d", k), cnt0, 32'((k - 1) % 16));
        end
        i_valid = 1'b0;
        tick();
        check("wrap_o0_valid_end", o0_valid, 0);
        check("wrap_cnt0", cnt0, 1);
        check("wrap_cnt1", cnt1, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
